// File: rtl/generador_estimulos.sv
`timescale 1ns/1ps
// generador_estimulos: start-triggered burst word source (counter / walking-one / optional LFSR)
// over valid/ready. Defining GEN_LFSR_EN enables the Fibonacci LFSR in mode 2.
module generador_estimulos #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      COUNT_W   = 16,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] length,
  input  logic [WIDTH-1:0]   seed,
  input  logic               ready,
  output logic [WIDTH-1:0]   word,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sent_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0]   word_d;
  logic               valid_d, busy_d, done_d;
  logic [COUNT_W-1:0] cnt_d;

`ifndef GEN_LFSR_EN
  logic unused_taps;
  assign unused_taps = ^LFSR_TAPS;
`endif

  // Successor of the current word; modes 2 (without LFSR) and 3 fall back to counting.
  function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m, input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w + WIDTH'(1);
    if (m == 2'd1) r = {w[WIDTH-2:0], w[WIDTH-1]};
`ifdef GEN_LFSR_EN
    if (m == 2'd2) r = {w[WIDTH-2:0], ^(w & LFSR_TAPS)};
`endif
    return r;
  endfunction

  // Rotating/shifting modes would lock up on an all-zero seed, so it is loaded as 1.
  function automatic logic [WIDTH-1:0] load_seed(input logic [1:0] m, input logic [WIDTH-1:0] s);
    logic needs_one;
    needs_one = (m == 2'd1);
`ifdef GEN_LFSR_EN
    needs_one = needs_one || (m == 2'd2);
`endif
    return (needs_one && (s == '0)) ? WIDTH'(1) : s;
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    word_d  = word;
    valid_d = valid;
    busy_d  = busy;
    done_d  = 1'b0;
    cnt_d   = sent_cnt;
    if (abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_d  = '0;
            mode_d = mode;
            len_d  = length;
            if (length == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
              word_d  = load_seed(mode, seed);
              valid_d = 1'b1;
              busy_d  = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (valid && ready) begin
            cnt_d  = sent_cnt + COUNT_W'(1);
            word_d = next_word(mode_q, word);
            if (cnt_d == len_q) begin
              state_d = S_DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
            end
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      len_q    <= '0;
      word     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sent_cnt <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      word     <= word_d;
      valid    <= valid_d;
      busy     <= busy_d;
      done     <= done_d;
      sent_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_generador_estimulos.sv
`timescale 1ns/1ps
// Scoreboard bench for generador_estimulos: directed bursts push expected words, a monitor
// pops and compares on every valid&&ready transfer.
module tb_generador_estimulos;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, ready;
  logic [1:0]  mode;
  logic [15:0] length, sent_cnt;
  logic [7:0]  seed, word;
  logic        valid, busy, done;

  logic [7:0]  exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          cyc;
  int          d0;

  generador_estimulos dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .length(length), .seed(seed), .ready(ready), .word(word), .valid(valid),
    .busy(busy), .done(done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the transfer happens at the next rising edge, sampled here on the falling edge.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_word: got %0h, expected no transfer at %0t", word, $time);
      end else begin
        chk("word", 32'(word), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [7:0] s, input logic [15:0] l);
    mode = m; seed = s; length = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done, expected done within 100 clks");
    end
  endtask

  task automatic push(input logic [7:0] w);
    exp_q.push_back(w);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    mode = 2'd0; length = 16'd0; seed = 8'd0;
    #12;
    chk("rst_word", 32'(word), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(sent_cnt), 0);
    rst_n = 1'b1;
    tick();

    // T1 counter with wrap, back-to-back
    push(8'hFE); push(8'hFF); push(8'h00); push(8'h01);
    d0 = done_cnt;
    pulse_start(2'd0, 8'hFE, 16'd4);
    chk("t1_valid_lat", 32'(valid), 1);
    chk("t1_busy", 32'(busy), 1);
    wait_done(cyc);
    chk("t1_cycles", 32'(cyc), 5);
    chk("t1_cnt", 32'(sent_cnt), 4);
    chk("t1_valid_end", 32'(valid), 0);
    tick();
    chk("t1_done_1cyc", 32'(done), 0);
    chk("t1_done_once", 32'(done_cnt - d0), 1);
    chk("t1_q_empty", 32'(exp_q.size()), 0);

    // T2 walking-one, seed 0 loaded as 1, wraps MSB->LSB
    for (int i = 0; i < 8; i++) push(8'(1 << i));
    push(8'h01);
    pulse_start(2'd1, 8'h00, 16'd9);
    wait_done(cyc);
    chk("t2_cycles", 32'(cyc), 10);
    chk("t2_cnt", 32'(sent_cnt), 9);
    tick();

    // T3 backpressure holds word/valid/sent_cnt
    ready = 1'b0;
    push(8'h10); push(8'h11); push(8'h12);
    pulse_start(2'd0, 8'h10, 16'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_word", 32'(word), 32'h10);
      chk("t3_hold_valid", 32'(valid), 1);
      chk("t3_hold_cnt", 32'(sent_cnt), 0);
      tick();
    end
    ready = 1'b1;
    wait_done(cyc);
    chk("t3_cycles", 32'(cyc), 4);
    chk("t3_cnt", 32'(sent_cnt), 3);
    tick();

    // T4 abort after two transfers
    push(8'h20); push(8'h21);
    d0 = done_cnt;
    pulse_start(2'd0, 8'h20, 16'd10);
    tick(); tick();
    ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; ready = 1'b1;
    chk("t4_valid", 32'(valid), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_cnt", 32'(sent_cnt), 2);
    tick(); tick(); tick();
    chk("t4_no_done", 32'(done_cnt - d0), 0);
    chk("t4_cnt_kept", 32'(sent_cnt), 2);

    // T5 zero length: done two clocks after start, no word
    pulse_start(2'd0, 8'h55, 16'd0);
    chk("t5_valid_a", 32'(valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done_early", 32'(done), 0);
    tick();
    chk("t5_done", 32'(done), 1);
    chk("t5_valid_b", 32'(valid), 0);
    tick();

    // T5b start while busy is ignored
    push(8'h40); push(8'h41); push(8'h42);
    pulse_start(2'd0, 8'h40, 16'd3);
    pulse_start(2'd1, 8'h99, 16'd1);
    wait_done(cyc);
    chk("t5b_cycles", 32'(cyc), 3);
    chk("t5b_cnt", 32'(sent_cnt), 3);
    tick();

    // T6 mode 2: LFSR when enabled, otherwise counter
`ifdef GEN_LFSR_EN
    push(8'h01); push(8'h02); push(8'h04); push(8'h08); push(8'h11);
`else
    for (int i = 1; i <= 5; i++) push(8'(i));
`endif
    pulse_start(2'd2, 8'h01, 16'd5);
    wait_done(cyc);
    chk("t6_cycles", 32'(cyc), 6);
    chk("t6_cnt", 32'(sent_cnt), 5);
    tick();

    // T6b asynchronous reset mid-burst
    push(8'h80); push(8'h81);
    d0 = done_cnt;
    pulse_start(2'd0, 8'h80, 16'd8);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t6b_word", 32'(word), 0);
    chk("t6b_valid", 32'(valid), 0);
    chk("t6b_busy", 32'(busy), 0);
    chk("t6b_done", 32'(done), 0);
    chk("t6b_cnt", 32'(sent_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t6b_no_done", 32'(done_cnt - d0), 0);
    chk("t6b_valid_idle", 32'(valid), 0);
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200us");
    $fatal(1, "watchdog");
  end

endmodule
